// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: feeder FSM states, default bit
// timing and a width helper that never returns zero.
package uart_pkg;

  localparam int DEFAULT_CLK_PER_BIT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } tx_state_e;

  // Bits needed to index 'value' entries; at least 1 so a 1-deep structure still gets a wire.
  function automatic int clog2_safe(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular byte FIFO: one write port, one asynchronous read port, occupancy count
// and a synchronous flush that clears pointers and level.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = clog2_safe(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // Flush takes priority over both ports so a same-cycle write is simply dropped.
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // NOTE: the array is deliberately left out of reset; an entry is always written
  // before it is read, and a reset-free array can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      level <= level + 1'b1;
      else if (do_rd && !do_wr) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch sequencer in front of the UART transmitter: one frame at
// a time, tx_data held until tx_done, then a guard gap before the next launch.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
  parameter int GAP_CYCLES  = CLK_PER_BIT + 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_done,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   overflow
);

  localparam int               GAP_W    = clog2_safe(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  tx_state_e         state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              launch;

  // A byte being flushed this cycle must not be launched from the stale read port.
  assign launch   = (state == IDLE) && !fifo_empty && !flush;
  assign in_ready = !fifo_full;
  assign tx_start = (state == LAUNCH);
  assign busy     = (state != IDLE);

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (in_valid && in_ready),
    .wr_data (in_data),
    .rd_en   (launch),
    .rd_data (fifo_rd_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            tx_data <= fifo_rd_data;
            state   <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          if (tx_done) begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state   <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow <= 1'b0;
    else if (flush)                  overflow <= 1'b0;
    else if (in_valid && !in_ready)  overflow <= 1'b1;
  end

endmodule
